// File: rtl/draw_cmd_pkg.sv
// Shared definitions for draw commands, used by the command FIFO and the draw unit.
// A command is CMD_WORDS 16-bit words, and word k sits in bits [16k+15:16k].
package draw_cmd_pkg;

  localparam int WORD_W        = 16;
  localparam int CMD_WORDS_DEF = 4;
  localparam int CMD_W         = WORD_W * CMD_WORDS_DEF;

  typedef logic [WORD_W-1:0] word_t;

  // Word index of each field inside a command.
  typedef enum int unsigned {
    F_OPCODE = 0,
    F_X0     = 1,
    F_Y0     = 2,
    F_X1     = 3
  } cmd_field_e;

  function automatic int field_lsb(cmd_field_e f);
    return int'(f) * WORD_W;
  endfunction

endpackage

// File: rtl/cmd_fifo_core.sv
// Generic synchronous first-word-fall-through FIFO with push, pop, level and flush.
// A push is ignored when the FIFO is full, and a pop is ignored when it is empty.
module cmd_fifo_core #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [PTR_W:0]   o_level
);

  localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && (r_level != FULL_LEVEL);
  assign w_pop  = i_pop && (r_level != '0);

  // NOTE: the storage is reset on purpose so that the head reads as zero after reset; flush leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_valid = (r_level != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/draw_cmd_fifo.sv
// Assembles CPU word writes into draw commands and queues the complete commands for the draw unit.
// The full flag provides backpressure. A word written while the FIFO is full is dropped and sets overflow.
module draw_cmd_fifo
  import draw_cmd_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int CMD_WORDS = CMD_WORDS_DEF,
  parameter int PTR_W     = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        we,
  input  logic [WORD_W-1:0]           dataIn,
  input  logic                        flush,
  output logic                        full,
  output logic                        overflow,
  output logic                        cmd_valid,
  output logic [WORD_W*CMD_WORDS-1:0] cmd_data,
  input  logic                        cmd_ready,
  output logic [PTR_W:0]              level
);

  localparam int             IDX_W    = (CMD_WORDS > 1) ? $clog2(CMD_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CMD_WORDS - 1);

  word_t                       r_asm [CMD_WORDS];
  logic [IDX_W-1:0]            r_widx;
  logic                        r_overflow;
  logic [WORD_W*CMD_WORDS-1:0] w_cmd;
  logic [PTR_W:0]              w_level;
  logic                        w_full;
  logic                        w_accept;
  logic                        w_drop;
  logic                        w_last;

  assign w_full   = (w_level == (PTR_W+1)'(DEPTH));
  assign w_accept = we && !w_full && !flush;
  assign w_drop   = we && w_full && !flush;
  assign w_last   = (r_widx == LAST_IDX);

  // The final word comes straight from dataIn, so the command is pushed on the same edge that completes it.
  // NOTE: w_cmd gets a default before the loop, so every path assigns it and no latch is inferred.
  always_comb begin
    w_cmd = '0;
    for (int k = 0; k < CMD_WORDS; k++) w_cmd[k*WORD_W +: WORD_W] = r_asm[k];
    w_cmd[(CMD_WORDS-1)*WORD_W +: WORD_W] = dataIn;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < CMD_WORDS; k++) r_asm[k] <= '0;
      r_widx     <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_widx     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_asm[r_widx] <= dataIn;
        r_widx        <= w_last ? '0 : r_widx + 1'b1;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  cmd_fifo_core #(
    .WIDTH (WORD_W * CMD_WORDS),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_accept && w_last),
    .i_push_data (w_cmd),
    .i_pop       (cmd_ready),
    .i_flush     (flush),
    .o_valid     (cmd_valid),
    .o_data      (cmd_data),
    .o_level     (w_level)
  );

  assign full     = w_full;
  assign overflow = r_overflow;
  assign level    = w_level;

endmodule

// File: tb/tb_draw_cmd_fifo.sv
// Self-checking bench for draw_cmd_fifo. Expected commands are queued in a scoreboard when they are written.
// A monitor compares them against the head command whenever the draw unit pops one.
module tb_draw_cmd_fifo;

  localparam int DEPTH     = 16;
  localparam int CMD_WORDS = 4;
  localparam int CMD_W     = 16 * CMD_WORDS;

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic             we        = 1'b0;
  logic [15:0]      dataIn    = '0;
  logic             flush     = 1'b0;
  logic             cmd_ready = 1'b0;
  logic             full;
  logic             overflow;
  logic             cmd_valid;
  logic [CMD_W-1:0] cmd_data;
  logic [4:0]       level;

  int               n_checks = 0;
  int               n_errors = 0;
  logic [CMD_W-1:0] sb_q[$];

  draw_cmd_fifo #(
    .DEPTH     (DEPTH),
    .CMD_WORDS (CMD_WORDS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .dataIn    (dataIn),
    .flush     (flush),
    .full      (full),
    .overflow  (overflow),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .level     (level)
  );

  always #20 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // The monitor samples on the falling edge. It compares each command that the next rising edge will pop.
  always @(negedge clk) begin
    if (!reset && cmd_valid && cmd_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got 0x%0h expected no command", cmd_data);
      end else begin
        check("sb_pop", cmd_data, sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [CMD_W-1:0] mk(input logic [15:0] w0, input logic [15:0] w1,
                                          input logic [15:0] w2, input logic [15:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [15:0] w);
    we     = 1'b1;
    dataIn = w;
    tick();
    we     = 1'b0;
  endtask

  task automatic write_cmd(input logic [CMD_W-1:0] c);
    sb_q.push_back(c);
    for (int k = 0; k < CMD_WORDS; k++) write_word(c[k*16 +: 16]);
  endtask

  task automatic pop_n(input int n);
    cmd_ready = 1'b1;
    repeat (n) tick();
    cmd_ready = 1'b0;
  endtask

  initial begin
    logic [CMD_W-1:0] c;
    logic [4:0]       max_lvl;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_valid", cmd_valid, 0);
    check("rst_level", level, 0);
    check("rst_data", cmd_data, 0);

    // The first command appears on the edge of its fourth word
    sb_q.push_back(64'h0044_0033_0022_0011);
    write_word(16'h0011);
    write_word(16'h0022);
    write_word(16'h0033);
    check("partial_not_valid", cmd_valid, 0);
    write_word(16'h0044);
    check("t1_valid", cmd_valid, 1);
    check("t1_data", cmd_data, 64'h0044_0033_0022_0011);
    check("t1_level", level, 1);
    pop_n(1);
    check("t1_pop_level", level, 0);
    check("t1_pop_valid", cmd_valid, 0);

    // Fill the FIFO, overflow it, then drain it
    for (int i = 0; i < DEPTH; i++)
      write_cmd(mk(16'(i), 16'(16'h0100 + i), 16'(16'h0200 + i), 16'(16'h0300 + i)));
    check("fill_full", full, 1);
    check("fill_level", level, 16);
    check("fill_no_overflow", overflow, 0);
    write_word(16'hDEAD);
    check("ovf_set", overflow, 1);
    check("ovf_level", level, 16);
    check("ovf_head_word0", {48'h0, cmd_data[15:0]}, 0);
    pop_n(1);
    check("pop_clears_full", full, 0);
    check("pop_level", level, 15);
    pop_n(15);
    check("drain_level", level, 0);
    check("drain_valid", cmd_valid, 0);
    check("ovf_sticky", overflow, 1);

    // A reset in the middle of a command discards the partial words
    write_word(16'h00B1);
    write_word(16'h00B2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_overflow", overflow, 0);
    check("midrst_level", level, 0);
    write_cmd(64'h00A3_00A2_00A1_00A0);
    check("midrst_data", cmd_data, 64'h00A3_00A2_00A1_00A0);
    check("midrst_level1", level, 1);
    pop_n(1);

    // Steady streaming across the pointer wrap
    cmd_ready = 1'b1;
    max_lvl   = '0;
    for (int i = 0; i < 40; i++) begin
      c = mk(16'(16'h4000 + i), 16'(16'h5000 + i), 16'(16'h6000 + i), 16'(16'h7000 + i));
      sb_q.push_back(c);
      for (int k = 0; k < CMD_WORDS; k++) begin
        write_word(c[k*16 +: 16]);
        if (level > max_lvl) max_lvl = level;
      end
    end
    tick();
    tick();
    cmd_ready = 1'b0;
    check("stream_max_level", max_lvl, 1);
    check("stream_overflow", overflow, 0);
    check("stream_all_recv", sb_q.size(), 0);
    check("stream_level_end", level, 0);

    // A push and a pop on the same edge leave the level unchanged
    write_cmd(64'hE1E1_E1E1_E1E1_0E01);
    write_cmd(64'hE2E2_E2E2_E2E2_0E02);
    write_cmd(64'hE3E3_E3E3_E3E3_0E03);
    check("pp_level3", level, 3);
    sb_q.push_back(64'hE4E4_E4E4_E4E4_0E04);
    write_word(16'h0E04);
    write_word(16'hE4E4);
    write_word(16'hE4E4);
    cmd_ready = 1'b1;
    write_word(16'hE4E4);
    cmd_ready = 1'b0;
    check("pp_level_same", level, 3);
    check("pp_head", cmd_data, 64'hE2E2_E2E2_E2E2_0E02);
    pop_n(3);
    check("pp_drained", level, 0);

    // Flush clears the level and overflow, and the word presented with it is discarded
    for (int i = 0; i < DEPTH; i++)
      write_cmd(mk(16'(16'h0F00 + i), 16'h1111, 16'h2222, 16'(i)));
    write_word(16'hBEEF);
    pop_n(11);
    check("fl_pre_level", level, 5);
    check("fl_pre_overflow", overflow, 1);
    flush  = 1'b1;
    we     = 1'b1;
    dataIn = 16'hF00D;
    tick();
    flush  = 1'b0;
    we     = 1'b0;
    sb_q.delete();
    check("fl_level", level, 0);
    check("fl_valid", cmd_valid, 0);
    check("fl_overflow", overflow, 0);
    check("fl_full", full, 0);
    sb_q.push_back(64'h00C3_00C2_00C1_00C0);
    write_word(16'h00C0);
    write_word(16'h00C1);
    write_word(16'h00C2);
    check("fl_partial", cmd_valid, 0);
    write_word(16'h00C3);
    check("fl_cmd_level", level, 1);
    check("fl_cmd_data", cmd_data, 64'h00C3_00C2_00C1_00C0);
    pop_n(1);

    tick();
    check("sb_empty_end", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
